// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch constants: reset PC, bubble instruction and instruction field widths.
package fetch_stage_pkg;

    localparam int XLEN       = 32;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7_W   = 7;
    localparam int REG_IDX_W  = 5;

    localparam logic [XLEN-1:0] RESET_PC     = 32'h0000_0000;
    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP      = 32'h0000_0004;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirects, instruction BRAM port and IF/ID outputs.
interface fetch_stage_if
    import fetch_stage_pkg::*;
();

    logic                 StallF;
    logic                 StallD;
    logic                 FlushD;
    logic                 JalD;
    logic [XLEN-1:0]      JalTargetD;
    logic                 BranchE;
    logic [XLEN-1:0]      BranchTargetE;
    logic                 JalrE;
    logic [XLEN-1:0]      JalrTargetE;
    logic [XLEN-1:0]      PCF;
    logic [XLEN-1:0]      ImemRdata;
    logic [XLEN-1:0]      PCD;
    logic [XLEN-1:0]      InstrD;
    logic                 ValidD;
    logic [OPCODE_W-1:0]  OpD;
    logic [FUNCT3_W-1:0]  Fn3D;
    logic [FUNCT7_W-1:0]  Fn7D;
    logic [REG_IDX_W-1:0] Rs1D;
    logic [REG_IDX_W-1:0] Rs2D;
    logic [REG_IDX_W-1:0] RdD;

    modport master (
        input  StallF, StallD, FlushD, JalD, JalTargetD, BranchE, BranchTargetE,
               JalrE, JalrTargetE, ImemRdata,
        output PCF, PCD, InstrD, ValidD, OpD, Fn3D, Fn7D, Rs1D, Rs2D, RdD
    );

    modport slave (
        output StallF, StallD, FlushD, JalD, JalTargetD, BranchE, BranchTargetE,
               JalrE, JalrTargetE, ImemRdata,
        input  PCF, PCD, InstrD, ValidD, OpD, Fn3D, Fn7D, Rs1D, Rs2D, RdD
    );

endinterface

// File: rtl/fetch_stage_npc_sel.sv
// Next-PC selection: JALR over branch over JAL over sequential PC+4 (wraps modulo 2^32).
module fetch_stage_npc_sel
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jal_en,
    input  logic [XLEN-1:0] jal_target,
    output logic [XLEN-1:0] npc
);

    // Priority mux; EX redirects are older than the ID jump and so win.
    always_comb begin
        npc = pc + PC_STEP;
        if (jalr_en) begin
            npc = jalr_target;
        end else if (branch_en) begin
            npc = branch_target;
        end else if (jal_en) begin
            npc = jal_target;
        end else begin
            npc = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IF/ID register, and the path that hides the BRAM read latency.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET  = RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = BUBBLE_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] npc_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pcd_r;
    logic            valid_r;
    logic            flush_r;
    logic            stall_r;
    logic [XLEN-1:0] instr_hold_r;
    logic [XLEN-1:0] instr_s;

    fetch_stage_npc_sel u_npc_sel (
        .pc            (pc_r),
        .jalr_en       (bus.JalrE),
        .jalr_target   (bus.JalrTargetE),
        .branch_en     (bus.BranchE),
        .branch_target (bus.BranchTargetE),
        .jal_en        (bus.JalD),
        .jal_target    (bus.JalTargetD),
        .npc           (npc_s)
    );

    // PC register; a fetch stall overrides every redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= PC_RESET;
        end else if (!bus.StallF) begin
            pc_r <= npc_s;
        end
    end

    // IF/ID register: flush beats stall, and a flush leaves PCD untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcd_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (bus.FlushD) begin
            valid_r <= 1'b0;
        end else if (!bus.StallD) begin
            pcd_r   <= pc_r;
            valid_r <= 1'b1;
        end
    end

    // The BRAM keeps reading the live PC, so the last presented word is replayed while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_r      <= 1'b1;
            stall_r      <= 1'b0;
            instr_hold_r <= NOP_INSTR;
        end else begin
            flush_r      <= bus.FlushD;
            stall_r      <= bus.StallD & ~bus.FlushD;
            instr_hold_r <= instr_s;
        end
    end

    always_comb begin
        instr_s = bus.ImemRdata;
        if (flush_r) begin
            instr_s = NOP_INSTR;
        end else if (stall_r) begin
            instr_s = instr_hold_r;
        end else begin
            instr_s = bus.ImemRdata;
        end
    end

    assign bus.PCF    = pc_r;
    assign bus.PCD    = pcd_r;
    assign bus.ValidD = valid_r;
    assign bus.InstrD = instr_s;
    assign bus.OpD    = instr_s[6:0];
    assign bus.RdD    = instr_s[11:7];
    assign bus.Fn3D   = instr_s[14:12];
    assign bus.Rs1D   = instr_s[19:15];
    assign bus.Rs2D   = instr_s[24:20];
    assign bus.Fn7D   = instr_s[31:25];

endmodule
